// File: rtl/game_pkg.sv
// Shared definitions for the note generator and its neighbours (scoring, colour mapper).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    localparam int NUM_LANES   = 5;
    localparam int LANE_GREEN  = 0;
    localparam int LANE_RED    = 1;
    localparam int LANE_YELLOW = 2;
    localparam int LANE_BLUE   = 3;
    localparam int LANE_ORANGE = 4;

    // Hit window rows, used by the scoring block.
    localparam int Y_HIT_LO = 410;
    localparam int Y_HIT_HI = 440;

    // 13-bit chart word: mask in [12:8], delay in [7:0].
    typedef struct packed {
        logic [4:0] mask;
        logic [7:0] delay;
    } chart_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SPAWN,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/note_generator_if.sv
// Bundle between game control / renderer / scoring and the note generator.
// Latency: n/a (wires only).
// Backpressure: none; frame_tick and start are single-cycle pulses.
interface note_generator_if;
    logic       frame_tick;
    logic       start;
    logic [9:0] green_y_pos;
    logic [9:0] red_y_pos;
    logic [9:0] yellow_y_pos;
    logic [9:0] blue_y_pos;
    logic [9:0] orange_y_pos;
    logic [4:0] lane_active;
    logic       song_done;
    logic [7:0] drop_count;

    modport master (
        output frame_tick, start,
        input  green_y_pos, red_y_pos, yellow_y_pos, blue_y_pos, orange_y_pos,
        input  lane_active, song_done, drop_count
    );

    modport slave (
        input  frame_tick, start,
        output green_y_pos, red_y_pos, yellow_y_pos, blue_y_pos, orange_y_pos,
        output lane_active, song_done, drop_count
    );
endinterface

// File: rtl/note_chart_rom.sv
// Synchronous chart ROM; the chart image is a flat parameter, entry 0 in the low bits.
// Latency: 1 cycle from addr to data.
// Backpressure: none.
module note_chart_rom
    import game_pkg::*;
#(
    parameter int                         CHART_DEPTH = 64,
    parameter int                         ADDR_W      = 6,
    parameter logic [CHART_DEPTH*13-1:0]  CHART_IMAGE = '0
) (
    input  logic              Clk,
    input  logic [ADDR_W-1:0] addr,
    output chart_entry_t      data
);

    // Registered read of the addressed chart word.
    always_ff @(posedge Clk) begin
        data <= chart_entry_t'(CHART_IMAGE[int'(addr)*13 +: 13]);
    end

endmodule

// File: rtl/note_generator.sv
// Plays the note chart and moves one falling note per lane; optional NOTE_GEN_CHART_LOOP_EN repeats the chart.
// Latency: y_pos/lane_active update the cycle after the frame_tick or SPAWN; chart entry takes FETCH+DECODE+SPAWN.
// Backpressure: none; spawns onto a busy lane are dropped and counted (saturating at 255).
module note_generator
    import game_pkg::*;
#(
    parameter int SPEED       = 2,
    parameter int Y_START     = 0,
    parameter int Y_END       = 479,
    parameter int CHART_DEPTH = 64,
    parameter int ADDR_W      = 6,
    parameter logic [CHART_DEPTH*13-1:0] CHART_IMAGE =
        {{((CHART_DEPTH-3)*13){1'b0}}, 13'h0000, 13'h0610, 13'h0108}
) (
    input  logic              Clk,
    input  logic              Reset_n,
    note_generator_if.slave   bus
);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_delay;
    logic [7:0]          r_drop;
    logic [4:0]          r_active;
    logic [9:0]          r_y [NUM_LANES];

    chart_entry_t        w_entry;
    logic                w_end_marker;
    logic                w_spawn;
    logic [4:0]          w_busy;
    logic [2:0]          w_drop_inc;
    logic [8:0]          w_drop_sum;
    logic [10:0]         w_sum [NUM_LANES];

    note_chart_rom #(
        .CHART_DEPTH (CHART_DEPTH),
        .ADDR_W      (ADDR_W),
        .CHART_IMAGE (CHART_IMAGE)
    ) u_rom (
        .Clk  (Clk),
        .addr (r_addr),
        .data (w_entry)
    );

    assign w_end_marker = (w_entry.mask == 5'd0) && (w_entry.delay == 8'd0);
    assign w_spawn      = (r_state == S_SPAWN);
    // A retiring lane still has its active bit set this cycle, so it counts as busy.
    assign w_busy       = w_spawn ? (w_entry.mask & r_active) : 5'd0;
    assign w_drop_sum   = {1'b0, r_drop} + {6'd0, w_drop_inc};

    // Next-position sums and busy-lane popcount; 11-bit sums cannot wrap.
    always_comb begin
        w_drop_inc = 3'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_sum[i] = {1'b0, r_y[i]} + 11'(SPEED);
            if (w_busy[i]) begin
                w_drop_inc = w_drop_inc + 3'd1;
            end
        end
    end

    // Chart sequencer next-state logic.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.start) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_end_marker) begin
`ifdef NOTE_GEN_CHART_LOOP_EN
                    w_next_state = S_FETCH;
`else
                    w_next_state = S_DONE;
`endif
                end else begin
                    w_next_state = S_SPAWN;
                end
            end
            S_SPAWN:  w_next_state = S_WAIT;
            S_WAIT:   if (r_delay == 8'd0) w_next_state = S_FETCH;
            S_DONE:   if (bus.start) w_next_state = S_FETCH;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Chart address, frame delay counter and drop counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_addr  <= '0;
            r_delay <= 8'd0;
            r_drop  <= 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: if (bus.start) r_addr <= '0;
                S_DONE: begin
                    if (bus.start) begin
                        r_addr <= '0;
                        r_drop <= 8'd0;
                    end
                end
`ifdef NOTE_GEN_CHART_LOOP_EN
                S_DECODE: if (w_end_marker) r_addr <= '0;
`endif
                S_SPAWN: begin
                    r_delay <= w_entry.delay;
                    r_addr  <= (r_addr == ADDR_W'(CHART_DEPTH-1)) ? '0 : r_addr + 1'b1;
                    r_drop  <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
                end
                S_WAIT: if (bus.frame_tick && (r_delay != 8'd0)) r_delay <= r_delay - 8'd1;
                default: ;
            endcase
        end
    end

    // Per-lane spawn, advance and retirement; an idle-lane spawn beats the frame advance.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_active <= 5'd0;
            for (int i = 0; i < NUM_LANES; i++) r_y[i] <= 10'(Y_START);
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_spawn && w_entry.mask[i] && !r_active[i]) begin
                    r_y[i]      <= 10'(Y_START);
                    r_active[i] <= 1'b1;
                end else if (bus.frame_tick && r_active[i]) begin
                    if (w_sum[i] > 11'(Y_END)) begin
                        r_y[i]      <= 10'(Y_START);
                        r_active[i] <= 1'b0;
                    end else begin
                        r_y[i] <= w_sum[i][9:0];
                    end
                end
            end
        end
    end

    assign bus.green_y_pos  = r_y[LANE_GREEN];
    assign bus.red_y_pos    = r_y[LANE_RED];
    assign bus.yellow_y_pos = r_y[LANE_YELLOW];
    assign bus.blue_y_pos   = r_y[LANE_BLUE];
    assign bus.orange_y_pos = r_y[LANE_ORANGE];
    assign bus.lane_active  = r_active;
    assign bus.drop_count   = r_drop;
`ifdef NOTE_GEN_CHART_LOOP_EN
    assign bus.song_done    = 1'b0;
`else
    assign bus.song_done    = (r_state == S_DONE) && (r_active == 5'd0);
`endif

endmodule

// File: tb/tb_note_generator.sv
// Directed bench for note_generator: chart {00001,d3},{00011,d0},{00001,d5},end.
// Latency: n/a.
// Backpressure: n/a.
module tb_note_generator;

    localparam logic [64*13-1:0] CHART =
        {{(60*13){1'b0}}, 13'h0000, 13'h0105, 13'h0300, 13'h0103};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    note_generator_if ng ();

    note_generator #(
        .SPEED       (2),
        .Y_START     (0),
        .Y_END       (479),
        .CHART_DEPTH (64),
        .ADDR_W      (6),
        .CHART_IMAGE (CHART)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (ng.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ticks;
        int green;
        int red;
        int active;
        int drop;
        int done;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock with the given pulses, ending 1ns after the edge.
    task automatic step(input logic ft, input logic st);
        ng.frame_tick = ft;
        ng.start      = st;
        @(posedge clk);
        #1;
        ng.frame_tick = 1'b0;
        ng.start      = 1'b0;
    endtask

    task automatic tick();
        step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
    endtask

    task automatic apply_row(input int r);
        for (int k = 0; k < tbl[r].ticks; k++) tick();
        chk($sformatf("row%0d green", r),  int'(ng.green_y_pos), tbl[r].green);
        chk($sformatf("row%0d red", r),    int'(ng.red_y_pos),   tbl[r].red);
        chk($sformatf("row%0d active", r), int'(ng.lane_active), tbl[r].active);
        chk($sformatf("row%0d drop", r),   int'(ng.drop_count),  tbl[r].drop);
        chk($sformatf("row%0d done", r),   int'(ng.song_done),   tbl[r].done);
    endtask

    // Start pulse through the first three chart entries, with ticks placed on the SPAWN cycles.
    task automatic run_chart();
        step(1'b0, 1'b1);                       // -> FETCH
        chk("start drop cleared", int'(ng.drop_count), 0);
        chk("start done low",     int'(ng.song_done),  0);
        step(1'b0, 1'b0);                       // -> DECODE
        step(1'b0, 1'b0);                       // -> SPAWN
        step(1'b1, 1'b0);                       // spawn green with coincident tick
        chk("idle spawn+tick green", int'(ng.green_y_pos), 0);
        chk("idle spawn+tick active", int'(ng.lane_active), 1);
        tick();
        tick();
        step(1'b1, 1'b0);                       // third delay tick
        chk("3 ticks green", int'(ng.green_y_pos), 6);
        step(1'b0, 1'b0);                       // -> FETCH
        step(1'b0, 1'b0);                       // -> DECODE
        step(1'b0, 1'b0);                       // -> SPAWN {00011}
        step(1'b1, 1'b0);                       // busy green + tick, red spawns
        chk("busy+tick green", int'(ng.green_y_pos), 8);
        chk("busy+tick red",   int'(ng.red_y_pos),   0);
        chk("busy+tick active", int'(ng.lane_active), 3);
        chk("busy+tick drop",  int'(ng.drop_count),  1);
        repeat (4) step(1'b0, 1'b0);            // delay 0 refetch, SPAWN {00001}
        chk("second drop",  int'(ng.drop_count),  2);
        chk("second green", int'(ng.green_y_pos), 8);
        chk("second red",   int'(ng.red_y_pos),   0);
    endtask

    task automatic full_run();
        run_chart();
        for (int r = 0; r < 2; r++) apply_row(r);
        // Green walks 420..478 (covers 442..478) one tick at a time.
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk($sformatf("pass green %0d", 418 + 2*k), int'(ng.green_y_pos), 418 + 2*k);
        end
        chk("pass red", int'(ng.red_y_pos), 470);
        for (int r = 2; r < 6; r++) apply_row(r);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        ng.frame_tick = 1'b0;
        ng.start      = 1'b0;

        tbl[0] = '{ticks: 5,   green: 18,  red: 10,  active: 3, drop: 2, done: 0};
        tbl[1] = '{ticks: 200, green: 418, red: 410, active: 3, drop: 2, done: 0};
        tbl[2] = '{ticks: 1,   green: 0,   red: 472, active: 2, drop: 2, done: 0};
        tbl[3] = '{ticks: 3,   green: 0,   red: 478, active: 2, drop: 2, done: 0};
        tbl[4] = '{ticks: 1,   green: 0,   red: 0,   active: 0, drop: 2, done: 1};
        tbl[5] = '{ticks: 2,   green: 0,   red: 0,   active: 0, drop: 2, done: 1};

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset green",  int'(ng.green_y_pos),  0);
        chk("reset orange", int'(ng.orange_y_pos), 0);
        chk("reset active", int'(ng.lane_active),  0);
        chk("reset drop",   int'(ng.drop_count),   0);
        chk("reset done",   int'(ng.song_done),    0);

        // Ticks while idle move nothing.
        tick();
        chk("idle tick green", int'(ng.green_y_pos), 0);

        full_run();
        // Restart from DONE must replay identically.
        full_run();

        // Reset in the middle of a fall.
        run_chart();
        apply_row(0);
        for (int k = 0; k < 91; k++) tick();
        chk("pre-reset green", int'(ng.green_y_pos), 200);
        #3 rst_n = 1'b0;
        #1;
        chk("async reset green",  int'(ng.green_y_pos), 0);
        chk("async reset red",    int'(ng.red_y_pos),   0);
        chk("async reset active", int'(ng.lane_active), 0);
        chk("async reset drop",   int'(ng.drop_count),  0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();
        chk("post-reset idle green",  int'(ng.green_y_pos), 0);
        chk("post-reset idle active", int'(ng.lane_active), 0);
        run_chart();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
